// File: rtl/key_schedule_ctrl.sv
// PRESENT-80 round-key sequencer.
// Loads an 80-bit cipher key and streams round keys K0..K(NUM_KEYS-1) to the
// round datapath, one key per valid/ready transfer. A single combinational
// key_schedule step advances the key register on every accepted transfer.
//
// Handshake: a round key transfers on a rising clock edge where
// rk_valid && rk_ready. While rk_valid is high and rk_ready is low, rk, rk_idx
// and rk_valid hold steady. rk_valid never drops without a transfer except
// under reset.

`timescale 1ns/1ps

// One PRESENT-80 key schedule step for round counter round_cnt:
// rotate left by 61, S-box the top nibble, XOR the counter into bits [19:15].
module key_schedule (
  input  logic [79:0] key_in,
  input  logic [4:0]  round_cnt,
  output logic [79:0] key_out
);

  logic [79:0] rot;
  logic [3:0]  sbox_in;
  logic [3:0]  sbox_out;

  // PRESENT 4-bit S-box, applied only to the top nibble of the rotated key
  always_comb begin
    sbox_out = 4'h0;
    case (sbox_in)
      4'h0: sbox_out = 4'hC;
      4'h1: sbox_out = 4'h5;
      4'h2: sbox_out = 4'h6;
      4'h3: sbox_out = 4'hB;
      4'h4: sbox_out = 4'h9;
      4'h5: sbox_out = 4'h0;
      4'h6: sbox_out = 4'hA;
      4'h7: sbox_out = 4'hD;
      4'h8: sbox_out = 4'h3;
      4'h9: sbox_out = 4'hE;
      4'hA: sbox_out = 4'hF;
      4'hB: sbox_out = 4'h8;
      4'hC: sbox_out = 4'h4;
      4'hD: sbox_out = 4'h7;
      4'hE: sbox_out = 4'h1;
      4'hF: sbox_out = 4'h2;
      default: sbox_out = 4'h0;
    endcase
  end

  // Rotate, substitute and mix in the round counter
  always_comb begin
    rot     = {key_in[18:0], key_in[79:19]};
    sbox_in = rot[79:76];
    key_out = {sbox_out, rot[75:20], rot[19:15] ^ round_cnt, rot[14:0]};
  end

endmodule

module key_schedule_ctrl #(
  parameter int NUM_KEYS = 32  // legal range 2..32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic [79:0] key,
  output logic        busy,
  output logic [63:0] rk,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [4:0]  rk_idx,
  output logic        rk_last,
  output logic        done,
  output logic        state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_KEYS - 1);

  state_t      state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [4:0]  idx_q, idx_d;
  logic        done_q, done_d;

  logic [4:0]  round_cnt;
  logic [79:0] next_key;
  logic        at_last;
  logic        xfer;

  // Round counter for the next key is always idx+1; it only feeds the step
  // while idx < LAST_IDX, so it stays within 1..31 and never wraps.
  assign round_cnt = idx_q + 5'd1;

  key_schedule u_step (
    .key_in    (key_q),
    .round_cnt (round_cnt),
    .key_out   (next_key)
  );

  // State, key, index and done-pulse registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= 80'h0;
      idx_q   <= 5'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: load in IDLE, advance on each transfer in RUN, and
  // return to IDLE after the last key, leaving key/index at final values
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    rk_valid = 1'b0;
    busy     = 1'b0;
    at_last  = (idx_q == LAST_IDX);
    xfer     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld) begin
          key_d   = key;
          idx_d   = 5'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        rk_valid = 1'b1;
        busy     = 1'b1;
        xfer     = rk_ready;
        if (xfer) begin
          if (at_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d = next_key;
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output mapping: round key is the top 64 bits of the key register
  always_comb begin
    rk        = key_q[79:16];
    rk_idx    = idx_q;
    rk_last   = rk_valid && at_last;
    done      = done_q;
    state_dbg = state_q;
  end

endmodule
